// File: rtl/radio_deserializer.sv
// rtl/radio_deserializer.sv - serial frame deserializer with sync lock FSM and pattern checker
// Recovers FRAME_BITS-wide words from an LSB-first stream framed by SYNC_IN pulses.
module radio_deserializer #(
  parameter int FRAME_BITS  = 4,
  parameter int LOCK_FRAMES = 4
) (
  input  logic                  FAST_CLK,
  input  logic                  RST_N,
  input  logic                  DATA_IN,
  input  logic                  SYNC_IN,
  input  logic                  CHECK_EN,
  output logic [FRAME_BITS-1:0] DATA_OUT,
  output logic                  DATA_VALID,
  output logic                  LOCKED,
  output logic [7:0]            SYNC_ERRS,
  output logic [15:0]           CHECK_ERRS
);
  localparam int CW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] FIRST_CNT = CW'(1 % FRAME_BITS);
  localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_BITS - 1);
  localparam logic [GW-1:0] LOCK_CNT  = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

  state_t                  state_q;
  logic [CW-1:0]           bitcnt_q;
  logic [GW-1:0]           good_q;
  logic [FRAME_BITS-1:0]   word_q;
  logic [FRAME_BITS-1:0]   word_d;
  logic [FRAME_BITS-1:0]   data_q;
  logic [FRAME_BITS-1:0]   ref_q;
  logic [FRAME_BITS-1:0]   ref_inc;
  logic                    valid_q;
  logic                    locked_q;
  logic                    ref_valid_q;
  logic [7:0]              sync_errs_q;
  logic [15:0]             check_errs_q;

  logic at_bit0;
  logic last_bit;
  logic early_sync;
  logic missing_sync;
  logic sync_err;
  logic stay_locked;
  logic deliver;

  // Word as it stands once the current bit lands in its slot.
  always_comb begin
    word_d           = word_q;
    word_d[bitcnt_q] = DATA_IN;
  end

  assign ref_inc      = ref_q + FRAME_BITS'(1);
  assign at_bit0      = (bitcnt_q == '0);
  assign last_bit     = (bitcnt_q == LAST_CNT);
  assign early_sync   = (state_q != ST_HUNT) && SYNC_IN && !at_bit0;
  assign missing_sync = (state_q != ST_HUNT) && !SYNC_IN && at_bit0;
  assign sync_err     = early_sync || missing_sync;
  assign stay_locked  = (state_q == ST_LOCKED) && !sync_err;
  assign deliver      = stay_locked && last_bit;

  always_ff @(posedge FAST_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_HUNT;
      bitcnt_q     <= '0;
      good_q       <= '0;
      word_q       <= '0;
      data_q       <= '0;
      ref_q        <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      ref_valid_q  <= 1'b0;
      sync_errs_q  <= '0;
      check_errs_q <= '0;
    end else begin
      valid_q     <= 1'b0;
      ref_valid_q <= CHECK_EN && stay_locked && (ref_valid_q || deliver);
      if (sync_err && sync_errs_q != 8'hFF) sync_errs_q <= sync_errs_q + 8'd1;
      if (deliver) begin
        data_q  <= word_d;
        valid_q <= 1'b1;
        ref_q   <= word_d;
        if (CHECK_EN && ref_valid_q && word_d != ref_inc && check_errs_q != 16'hFFFF)
          check_errs_q <= check_errs_q + 16'd1;
      end
      case (state_q)
        ST_HUNT: begin
          if (SYNC_IN) begin
            word_q[0] <= DATA_IN;
            bitcnt_q  <= FIRST_CNT;
            good_q    <= '0;
            state_q   <= ST_VERIFY;
          end
        end
        default: begin
          if (early_sync) begin
            // Realign on the unexpected marker rather than waiting for the old phase.
            word_q[0] <= DATA_IN;
            bitcnt_q  <= FIRST_CNT;
            good_q    <= '0;
            state_q   <= ST_VERIFY;
            locked_q  <= 1'b0;
          end else if (missing_sync) begin
            bitcnt_q <= '0;
            state_q  <= ST_HUNT;
            locked_q <= 1'b0;
          end else begin
            word_q   <= word_d;
            bitcnt_q <= last_bit ? '0 : bitcnt_q + CW'(1);
            if (state_q == ST_VERIFY && SYNC_IN) begin
              if (good_q == LOCK_CNT) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end else begin
                good_q <= good_q + GW'(1);
              end
            end
          end
        end
      endcase
    end
  end

  assign DATA_OUT   = data_q;
  assign DATA_VALID = valid_q;
  assign LOCKED     = locked_q;
  assign SYNC_ERRS  = sync_errs_q;
  assign CHECK_ERRS = check_errs_q;

endmodule

// File: tb/tb_radio_deserializer.sv
// tb/tb_radio_deserializer.sv - scoreboard bench for radio_deserializer
// A frame-level reference model queues expected words and per-cycle status; a monitor compares.
module tb_radio_deserializer;
  localparam int FB = 4;
  localparam int LF = 2;

  logic          clk = 1'b0;
  logic          rst_n, din, sin, cen;
  logic [FB-1:0] dout;
  logic          dvalid, locked;
  logic [7:0]    serrs;
  logic [15:0]   cerrs;

  logic          s_rst_n, s_din, s_sin, s_cen;
  logic [0:0]    s_dout;
  logic          s_dvalid, s_locked;
  logic [7:0]    s_serrs;
  logic [15:0]   s_cerrs;

  always #5 clk = ~clk;

  radio_deserializer #(.FRAME_BITS(FB), .LOCK_FRAMES(LF)) dut (
    .FAST_CLK(clk), .RST_N(rst_n), .DATA_IN(din), .SYNC_IN(sin), .CHECK_EN(cen),
    .DATA_OUT(dout), .DATA_VALID(dvalid), .LOCKED(locked),
    .SYNC_ERRS(serrs), .CHECK_ERRS(cerrs)
  );

  radio_deserializer #(.FRAME_BITS(1), .LOCK_FRAMES(2)) sat (
    .FAST_CLK(clk), .RST_N(s_rst_n), .DATA_IN(s_din), .SYNC_IN(s_sin), .CHECK_EN(s_cen),
    .DATA_OUT(s_dout), .DATA_VALID(s_dvalid), .LOCKED(s_locked),
    .SYNC_ERRS(s_serrs), .CHECK_ERRS(s_cerrs)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [FB-1:0] word; logic [15:0] cerr; } dv_t;
  typedef struct packed { logic lk; logic [7:0] serr; logic [FB-1:0] dout; } st_t;
  dv_t dv_q[$];
  st_t st_q[$];
  dv_t mon_dv;
  st_t mon_st;

  bit m_hunt, m_locked, m_refv;
  int m_pos, m_good, m_serr, m_cerr, m_ref, m_dout;
  bit m_bits[FB];
  bit ce_drv;

  logic [FB-1:0] pat [16] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB,
                              4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hunt = 1; m_locked = 0; m_refv = 0;
    m_pos = 0; m_good = 0; m_serr = 0; m_cerr = 0; m_ref = 0; m_dout = 0;
  endtask

  task automatic model_step(input bit d, input bit s, input bit ce);
    bit  deliver = 0;
    int  word = 0;
    dv_t e;
    st_t t;
    if (m_hunt) begin
      if (s) begin m_hunt = 0; m_bits[0] = d; m_pos = 1 % FB; m_good = 0; end
    end else if (s && m_pos != 0) begin
      m_serr = (m_serr < 255) ? m_serr + 1 : 255;
      m_bits[0] = d; m_pos = 1; m_good = 0; m_locked = 0;
    end else if (!s && m_pos == 0) begin
      m_serr = (m_serr < 255) ? m_serr + 1 : 255;
      m_hunt = 1; m_locked = 0;
    end else begin
      m_bits[m_pos] = d;
      if (m_locked && m_pos == FB - 1) deliver = 1;
      if (s && !m_locked) begin
        m_good++;
        if (m_good == LF) m_locked = 1;
      end
      m_pos = (m_pos + 1) % FB;
    end
    if (deliver) begin
      for (int i = 0; i < FB; i++) word += int'(m_bits[i]) * (1 << i);
      if (ce && m_refv && word != (m_ref + 1) % (1 << FB))
        m_cerr = (m_cerr < 65535) ? m_cerr + 1 : 65535;
      m_ref = word; m_dout = word;
      e.word = word[FB-1:0]; e.cerr = m_cerr[15:0];
      dv_q.push_back(e);
    end
    m_refv = ce && m_locked && (m_refv || deliver);
    t.lk = m_locked; t.serr = m_serr[7:0]; t.dout = m_dout[FB-1:0];
    st_q.push_back(t);
  endtask

  task automatic step(input bit d, input bit s);
    @(negedge clk);
    #1;
    din = d; sin = s; cen = ce_drv;
    model_step(d, s, ce_drv);
  endtask

  task automatic send_bits(input logic [FB-1:0] w, input int n, input bit s);
    for (int i = 0; i < n; i++) step(w[i], s && (i == 0));
  endtask

  task automatic send_frame(input logic [FB-1:0] w);
    send_bits(w, FB, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_data_out", dout, 0);
    check("rst_data_valid", dvalid, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_errs", serrs, 0);
    check("rst_check_errs", cerrs, 0);
    check("pending_words", dv_q.size(), 0);
    dv_q.delete();
    st_q.delete();
    model_reset();
    din = 1'b0; sin = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (dvalid) begin
      if (dv_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: DATA_VALID got 1 expected 0 (data %0h)", dout);
      end else begin
        mon_dv = dv_q.pop_front();
        check("word", dout, mon_dv.word);
        check("word_check_errs", cerrs, mon_dv.cerr);
      end
    end
    if (st_q.size() != 0) begin
      mon_st = st_q.pop_front();
      check("cycle_locked", locked, mon_st.lk);
      check("cycle_sync_errs", serrs, mon_st.serr);
      check("cycle_data_out", dout, mon_st.dout);
    end
  end

  initial begin
    logic [FB-1:0] pv;
    int r;
    rst_n = 1'b0; din = 1'b0; sin = 1'b0; cen = 1'b0; ce_drv = 1'b0;
    s_rst_n = 1'b0; s_din = 1'b0; s_sin = 1'b1; s_cen = 1'b1;
    model_reset();

    do_reset();

    // Lock acquisition: 0x3 and 0x4 delivered
    for (int i = 1; i <= 4; i++) send_frame(FB'(i));
    step(1'b0, 1'b1);
    check("lock_data_out", dout, 4);
    check("lock_locked", locked, 1);
    check("lock_sync_errs", serrs, 0);

    // Early sync at bit 2 of a locked frame
    do_reset();
    for (int i = 1; i <= 3; i++) send_frame(FB'(i));
    send_bits(4'h4, 2, 1'b1);
    for (int i = 6; i <= 9; i++) send_frame(FB'(i));
    step(1'b0, 1'b1);
    check("early_sync_errs", serrs, 1);
    check("early_data_out", dout, 9);
    check("early_locked", locked, 1);

    // Missing sync on a locked frame
    do_reset();
    for (int i = 1; i <= 3; i++) send_frame(FB'(i));
    send_bits(4'h4, FB, 1'b0);
    for (int i = 5; i <= 8; i++) send_frame(FB'(i));
    step(1'b0, 1'b1);
    check("miss_sync_errs", serrs, 1);
    check("miss_data_out", dout, 8);
    check("miss_locked", locked, 1);

    // Pattern checker with a skipped value and the F->0 wrap
    do_reset();
    ce_drv = 1'b1;
    for (int i = 0; i < 16; i++) send_frame(pat[i]);
    step(1'b0, 1'b1);
    check("pat_check_errs", cerrs, 1);
    check("pat_data_out", dout, 3);
    check("pat_sync_errs", serrs, 0);

    // Randomised stream with sync faults and CHECK_EN toggling
    do_reset();
    pv = '0;
    for (int f = 0; f < 500; f++) begin
      if ($urandom_range(0, 7) == 0) ce_drv = ~ce_drv;
      pv = ($urandom_range(0, 3) == 0) ? FB'($urandom) : pv + FB'(1);
      r = $urandom_range(0, 11);
      if (r == 0) send_bits(pv, FB, 1'b0);
      else if (r == 1) send_bits(pv, $urandom_range(1, FB - 1), 1'b1);
      else send_frame(pv);
    end
    step(1'b0, 1'b1);

    // Sync error saturation
    do_reset();
    for (int i = 0; i < 310; i++) step(1'($urandom), 1'b1);
    check("sync_errs_sat", serrs, 255);
    check("sat_locked", locked, 0);

    // Reset asserted at bit 1 of a locked frame
    do_reset();
    ce_drv = 1'b1;
    for (int i = 1; i <= 4; i++) send_frame(FB'(i));
    send_bits(4'h5, 2, 1'b1);
    do_reset();
    for (int i = 10; i <= 13; i++) send_frame(FB'(i));
    step(1'b0, 1'b1);
    check("relock_data_out", dout, 13);
    check("relock_locked", locked, 1);
    @(negedge clk);
    #1;
    check("final_pending_words", dv_q.size(), 0);
    check("final_pending_cycles", st_q.size(), 0);

    // CHECK_ERRS saturation on a one-bit-frame instance mismatching every word
    @(negedge clk);
    #1 s_rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    #1;
    check("cerr_mid_range", (s_cerrs > 0 && s_cerrs < 16'hFFFF), 1);
    repeat (66000) @(negedge clk);
    #1;
    check("cerr_saturated", s_cerrs, 16'hFFFF);
    repeat (20) @(negedge clk);
    #1;
    check("cerr_held", s_cerrs, 16'hFFFF);
    check("sat_inst_locked", s_locked, 1);
    check("sat_inst_valid", s_dvalid, 1);
    check("sat_inst_data", s_dout, 0);
    check("sat_inst_sync_errs", s_serrs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
